// File: rtl/gpio_pin_ctrl.sv
// GPIO pad controller: registered pad drive, input synchronize/debounce, sticky edge flags, level irq.
// Optional GPIO_OPEN_DRAIN_EN adds od_mode: selected pins only pull low and always read back the debounced level.
module gpio_pin_ctrl #(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             nrst,
`ifdef GPIO_OPEN_DRAIN_EN
  input  logic [WIDTH-1:0] od_mode,
`endif
  input  logic [WIDTH-1:0] io_out,
  input  logic [WIDTH-1:0] io_enable,
  output logic [WIDTH-1:0] io_in,
  input  logic [WIDTH-1:0] pad_in,
  output logic [WIDTH-1:0] pad_out,
  output logic [WIDTH-1:0] pad_oe,
  input  logic [WIDTH-1:0] irq_mask,
  input  logic [WIDTH-1:0] irq_clear,
  output logic [WIDTH-1:0] rise_flag,
  output logic [WIDTH-1:0] fall_flag,
  output logic             irq
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] od;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] stb_q;
  logic [WIDTH-1:0] stb_d;
  logic [WIDTH-1:0] rise_set;
  logic [WIDTH-1:0] fall_set;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

`ifdef GPIO_OPEN_DRAIN_EN
  assign od = od_mode;
`else
  assign od = '0;
`endif

  // Pad drive: open-drain pins never drive high, they release instead.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pad_out <= '0;
      pad_oe  <= '0;
    end else begin
      pad_out <= io_out & ~od;
      pad_oe  <= io_enable & ~(od & io_out);
    end
  end

  // Multi-flop synchronizer on the raw pad inputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= pad_in;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    stb_d = stb_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync[i] == stb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stb_d[i] = sync[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stb_q <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      stb_q <= stb_d;
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign rise_set = stb_d & ~stb_q;
  assign fall_set = ~stb_d & stb_q;

  // Sticky edge flags; a new edge outranks a same-cycle clear.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rise_flag <= '0;
      fall_flag <= '0;
    end else begin
      rise_flag <= (rise_flag & ~irq_clear) | rise_set;
      fall_flag <= (fall_flag & ~irq_clear) | fall_set;
    end
  end

  // Driven push-pull pins read back their own output; everything else reads the debounced level.
  assign io_in = (pad_oe & ~od & pad_out) | (~(pad_oe & ~od) & stb_q);
  assign irq   = |((rise_flag | fall_flag) & irq_mask);

endmodule

// File: tb/tb_gpio_pin_ctrl.sv
// Scoreboard bench for gpio_pin_ctrl: driver pushes model predictions, monitor pops and compares each cycle.
module tb_gpio_pin_ctrl;

  localparam int unsigned W    = 32;
  localparam int unsigned SYNC = 2;
  localparam int unsigned DEB  = 4;

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic [W-1:0] io_out = '0, io_enable = '0, pad_in = '0;
  logic [W-1:0] irq_mask = '0, irq_clear = '0, od_mode = '0;
  logic [W-1:0] io_in, pad_out, pad_oe, rise_flag, fall_flag;
  logic         irq;

  gpio_pin_ctrl #(.WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk       (clk),
    .nrst      (nrst),
`ifdef GPIO_OPEN_DRAIN_EN
    .od_mode   (od_mode),
`endif
    .io_out    (io_out),
    .io_enable (io_enable),
    .io_in     (io_in),
    .pad_in    (pad_in),
    .pad_out   (pad_out),
    .pad_oe    (pad_oe),
    .irq_mask  (irq_mask),
    .irq_clear (irq_clear),
    .rise_flag (rise_flag),
    .fall_flag (fall_flag),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] pout;
    logic [W-1:0] poe;
    logic [W-1:0] iin;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         irq;
  } exp_t;

  exp_t expq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: pad samples delayed SYNC edges, level accepted when the last DEB samples all disagree.
  logic [W-1:0] m_pipe[$];
  logic [W-1:0] m_win[$];
  logic [W-1:0] m_stb, m_rise, m_fall, m_pout, m_poe;

  function automatic void model_reset();
    m_pipe.delete();
    m_win.delete();
    for (int k = 0; k < int'(SYNC); k++) m_pipe.push_back('0);
    for (int k = 0; k < int'(DEB); k++) m_win.push_back('0);
    m_stb = '0; m_rise = '0; m_fall = '0; m_pout = '0; m_poe = '0;
  endfunction

  function automatic void chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endfunction

  task automatic step(input logic [W-1:0] pin, input logic [W-1:0] out, input logic [W-1:0] en,
                      input logic [W-1:0] mask, input logic [W-1:0] clr, input logic [W-1:0] od);
    logic [W-1:0] s_pre, chg, new_stb, iin;
    exp_t e;
    @(negedge clk);
    pad_in = pin; io_out = out; io_enable = en; irq_mask = mask; irq_clear = clr;
`ifdef GPIO_OPEN_DRAIN_EN
    od_mode = od;
`else
    od_mode = '0;
`endif
    s_pre = m_pipe.pop_front();
    m_pipe.push_back(pin);
    void'(m_win.pop_front());
    m_win.push_back(s_pre);
    chg = '1;
    foreach (m_win[k]) chg &= m_win[k] ^ m_stb;
    new_stb = m_stb ^ chg;
    m_rise  = (m_rise & ~clr) | (chg & new_stb);
    m_fall  = (m_fall & ~clr) | (chg & ~new_stb);
    m_stb   = new_stb;
    for (int i = 0; i < int'(W); i++) begin
`ifdef GPIO_OPEN_DRAIN_EN
      if (od[i]) begin
        m_pout[i] = 1'b0;
        m_poe[i]  = en[i] && !out[i];
        iin[i]    = m_stb[i];
        continue;
      end
`endif
      m_pout[i] = out[i];
      m_poe[i]  = en[i];
      iin[i]    = en[i] ? out[i] : m_stb[i];
    end
    e.pout = m_pout; e.poe = m_poe; e.iin = iin;
    e.rise = m_rise; e.fall = m_fall;
    e.irq  = |((m_rise | m_fall) & mask);
    expq.push_back(e);
  endtask

  // Monitor: every clock edge presents a new output set while out of reset.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (nrst && expq.size() > 0) begin
      e = expq.pop_front();
      chk("pad_out",   pad_out,   e.pout);
      chk("pad_oe",    pad_oe,    e.poe);
      chk("io_in",     io_in,     e.iin);
      chk("rise_flag", rise_flag, e.rise);
      chk("fall_flag", fall_flag, e.fall);
      chk("irq",       W'(irq),   W'(e.irq));
    end
  end

  task automatic do_reset(input logic [W-1:0] pin, input logic [W-1:0] out, input logic [W-1:0] en);
    @(negedge clk);
    pad_in = pin; io_out = out; io_enable = en; irq_mask = '1; irq_clear = '0;
    nrst = 1'b0;
    #1;
    chk("rst_pad_out",   pad_out,   '0);
    chk("rst_pad_oe",    pad_oe,    '0);
    chk("rst_io_in",     io_in,     '0);
    chk("rst_rise_flag", rise_flag, '0);
    chk("rst_fall_flag", fall_flag, '0);
    chk("rst_irq",       W'(irq),   '0);
    expq.delete();
    model_reset();
    @(posedge clk);
    #2 nrst = 1'b1;
  endtask

  logic [W-1:0] p, msk;

  initial begin
    model_reset();
    // Reset with all pads high, then release and hold.
    do_reset('1, '1, '0);
    repeat (8) step('1, '1, '0, '0, '0, '0);
    // Output path overrides readback on driven pins.
    repeat (3) step(W'($urandom), 32'h0000_00A5, 32'h0000_00FF, '0, '0, '0);
    // All pads low, then clear every flag.
    repeat (8) step('0, '0, '0, '0, '0, '0);
    step('0, '0, '0, '0, '1, '0);
    // Short pulse on pin 3 must be rejected; a long one accepted.
    repeat (3) step(32'h8, '0, '0, '0, '0, '0);
    repeat (6) step('0, '0, '0, '0, '0, '0);
    repeat (8) step(32'h8, '0, '0, '0, '0, '0);
    // Fall on pin 5, then mask and clear behaviour.
    repeat (8) step(32'h28, '0, '0, '0, '0, '0);
    repeat (8) step(32'h08, '0, '0, '0, '0, '0);
    step(32'h08, '0, '0, '0, '0, '0);
    step(32'h08, '0, '0, 32'h20, '0, '0);
    step(32'h08, '0, '0, 32'h20, 32'h20, '0);
    step(32'h08, '0, '0, 32'h20, '0, '0);
    // Clear pulse on pin 2 coincides with its rising edge.
    repeat (5) step(32'h0C, '0, '0, '1, '0, '0);
    step(32'h0C, '0, '0, '1, 32'h4, '0);
    step(32'h0C, '0, '0, '1, '0, '0);
    // Open-drain pin 0: drive low, then release.
    step(32'h0C, 32'h0, 32'h1, '1, '0, 32'h1);
    step(32'h0C, 32'h1, 32'h1, '1, '0, 32'h1);
    // Mid-run reset while counters are running.
    repeat (3) step('1, '0, '0, '1, '0, '0);
    do_reset('1, '0, '0);
    // Randomized traffic with sparse pad toggles and clears.
    p = '0;
    msk = W'($urandom);
    for (int n = 0; n < 2000; n++) begin
      p ^= W'($urandom) & W'($urandom) & W'($urandom);
      if ($urandom_range(0, 15) == 0) msk = W'($urandom);
      step(p, W'($urandom), W'($urandom), msk,
           W'($urandom) & W'($urandom) & W'($urandom), W'($urandom));
    end
    for (int n = 0; n < 10 && expq.size() > 0; n++) @(posedge clk);
    #2;
    if (expq.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
